// File: rtl/alu_decode_pkg.sv
// Shared decode constants and the registered decode bundle for the ALU decode stage.
package alu_decode_pkg;

    // Opcode classes (instr[6:2]) understood by the decoder.
    localparam logic [4:0] CLS_LOAD   = 5'd0;
    localparam logic [4:0] CLS_OPIMM  = 5'd4;
    localparam logic [4:0] CLS_AUIPC  = 5'd5;
    localparam logic [4:0] CLS_STORE  = 5'd8;
    localparam logic [4:0] CLS_R_TYPE = 5'd12;
    localparam logic [4:0] CLS_LUI    = 5'd13;
    localparam logic [4:0] CLS_BRANCH = 5'd24;
    localparam logic [4:0] CLS_JALR   = 5'd25;
    localparam logic [4:0] CLS_JAL    = 5'd27;
    // Stand-in class for encodings whose low two bits are not 2'b11.
    localparam logic [4:0] CLS_NONE   = 5'd31;

    // ALU funct3 codes, shared with the ALU.
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    // Branch funct3 codes, shared with the ALU.
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    // Everything the stage registers for the ALU and later stages.
    typedef struct packed {
        logic [2:0]  op;
        logic        f_sub;
        logic        f_sign;
        logic [31:0] data0;
        logic [31:0] data1;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        f_write;
        logic        f_load;
        logic        f_store;
        logic        f_branch;
        logic        f_jump;
        logic        f_illegal;
    } dec_t;

    // Classes that architecturally produce a register result.
    function automatic logic cls_writes_rd(input logic [4:0] cls);
        return (cls == CLS_LOAD)   || (cls == CLS_OPIMM) || (cls == CLS_AUIPC) ||
               (cls == CLS_R_TYPE) || (cls == CLS_LUI)   || (cls == CLS_JALR)  ||
               (cls == CLS_JAL);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; the format is chosen by opcode class.
module imm_gen
    import alu_decode_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [4:0]  cls,
    output logic [31:0] imm
);

    // Pick the I/S/B/U/J layout that matches the class; unknown classes yield 0.
    always_comb begin
        // NOTE: the output is given a default first so no path through the case can infer a latch.
        imm = '0;
        case (cls)
            CLS_LOAD, CLS_OPIMM, CLS_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            CLS_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            CLS_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            CLS_AUIPC, CLS_LUI:
                imm = {instr[31:12], 12'h000};
            CLS_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage feeding the ALU, with a one-cycle load-use bubble.
module alu_decode_stage (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    input  logic [31:0] i_Instr,
    input  logic [31:0] i_PC,
    input  logic [31:0] i_RsData0,
    input  logic [31:0] i_RsData1,
    input  logic        i_Stall,
    input  logic        i_Flush,
    output logic        o_Ready,
    output logic        o_Valid,
    output logic [2:0]  o_Op,
    output logic        o_fSub,
    output logic        o_fSign,
    output logic [31:0] o_Data0,
    output logic [31:0] o_Data1,
    output logic [31:0] o_Imm,
    output logic [4:0]  o_Rd,
    output logic        o_fWrite,
    output logic        o_fLoad,
    output logic        o_fStore,
    output logic        o_fBranchOp,
    output logic        o_fJump,
    output logic        o_fIllegal
);
    import alu_decode_pkg::*;

    logic [4:0]  cls;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        rs1_used;
    logic        rs2_used;
    logic        hazard;
    logic        accept;
    dec_t        dec_next;
    dec_t        dec_q;
    logic        valid_q;

    assign cls    = (i_Instr[1:0] == 2'b11) ? i_Instr[6:2] : CLS_NONE;
    assign funct3 = i_Instr[14:12];
    assign funct7 = i_Instr[31:25];
    assign rd     = i_Instr[11:7];
    assign rs1    = i_Instr[19:15];
    assign rs2    = i_Instr[24:20];

    imm_gen u_imm_gen (
        .instr (i_Instr[31:7]),
        .cls   (cls),
        .imm   (imm)
    );

    // Decode the presented instruction into the bundle loaded on accept.
    always_comb begin
        dec_next = '0;
        illegal  = 1'b0;
        case (cls)
            CLS_LOAD: begin
                dec_next.data0  = i_RsData0;
                dec_next.data1  = imm;
                dec_next.f_load = 1'b1;
            end
            CLS_OPIMM: begin
                dec_next.op     = funct3;
                dec_next.data0  = i_RsData0;
                dec_next.data1  = imm;
                dec_next.f_sub  = (funct3 == F3_SLT) || (funct3 == F3_SLTU);
                dec_next.f_sign = (funct3 == F3_SRL) && i_Instr[30];
                illegal = ((funct3 == F3_SLL) && (funct7 != FUNCT7_BASE)) ||
                          ((funct3 == F3_SRL) && (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT));
            end
            CLS_AUIPC: begin
                dec_next.data0 = i_PC;
                dec_next.data1 = imm;
            end
            CLS_STORE: begin
                dec_next.data0   = i_RsData0;
                dec_next.data1   = imm;
                dec_next.imm     = imm;
                dec_next.f_store = 1'b1;
                illegal = funct3 > 3'd2;
            end
            CLS_R_TYPE: begin
                dec_next.op     = funct3;
                dec_next.data0  = i_RsData0;
                dec_next.data1  = i_RsData1;
                dec_next.f_sub  = ((funct3 == F3_ADD) && i_Instr[30]) ||
                                  (funct3 == F3_SLT) || (funct3 == F3_SLTU);
                dec_next.f_sign = i_Instr[30] && ((funct3 == F3_ADD) || (funct3 == F3_SRL));
                illegal = !((funct7 == FUNCT7_BASE) ||
                            ((funct7 == FUNCT7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SRL))));
            end
            CLS_LUI: begin
                dec_next.data1 = imm;
            end
            CLS_BRANCH: begin
                dec_next.op       = funct3;
                dec_next.f_sub    = 1'b1;
                dec_next.data0    = i_RsData0;
                dec_next.data1    = i_RsData1;
                dec_next.imm      = imm;
                dec_next.f_branch = 1'b1;
                // funct3 2 and 3 are unassigned branch encodings.
                illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            CLS_JALR: begin
                dec_next.data0  = i_PC;
                dec_next.data1  = 32'd4;
                dec_next.imm    = imm;
                dec_next.f_jump = 1'b1;
                illegal = funct3 != 3'd0;
            end
            CLS_JAL: begin
                dec_next.data0  = i_PC;
                dec_next.data1  = 32'd4;
                dec_next.imm    = imm;
                dec_next.f_jump = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (cls_writes_rd(cls)) begin
            dec_next.rd = rd;
        end
        dec_next.f_write = cls_writes_rd(cls) && (rd != 5'd0) && !illegal;
        // An illegal instruction must have no architectural side effects downstream.
        if (illegal) begin
            dec_next.f_load   = 1'b0;
            dec_next.f_store  = 1'b0;
            dec_next.f_branch = 1'b0;
            dec_next.f_jump   = 1'b0;
        end
        dec_next.f_illegal = illegal;
    end

    // A load currently on the outputs cannot forward to a consumer in the next cycle.
    assign rs1_used = !((cls == CLS_LUI) || (cls == CLS_AUIPC) || (cls == CLS_JAL));
    assign rs2_used = (cls == CLS_R_TYPE) || (cls == CLS_STORE) || (cls == CLS_BRANCH);
    assign hazard   = valid_q && dec_q.f_load && (dec_q.rd != 5'd0) && i_Valid &&
                      ((rs1_used && (rs1 == dec_q.rd)) || (rs2_used && (rs2 == dec_q.rd)));
    assign o_Ready  = !i_Stall && !hazard;
    assign accept   = i_Valid && o_Ready && !i_Flush;

    // Pipeline register: reset, flush, stall-hold, hazard bubble, accept, drain.
    always_ff @(posedge i_Clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (i_Rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else if (i_Flush) begin
            valid_q <= 1'b0;
        end else if (i_Stall) begin
            valid_q <= valid_q;
            dec_q   <= dec_q;
        end else if (hazard) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            dec_q   <= dec_next;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign o_Valid     = valid_q;
    assign o_Op        = dec_q.op;
    assign o_fSub      = dec_q.f_sub;
    assign o_fSign     = dec_q.f_sign;
    assign o_Data0     = dec_q.data0;
    assign o_Data1     = dec_q.data1;
    assign o_Imm       = dec_q.imm;
    assign o_Rd        = dec_q.rd;
    assign o_fWrite    = dec_q.f_write;
    assign o_fLoad     = dec_q.f_load;
    assign o_fStore    = dec_q.f_store;
    assign o_fBranchOp = dec_q.f_branch;
    assign o_fJump     = dec_q.f_jump;
    assign o_fIllegal  = dec_q.f_illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: instruction-level model plus directed literal checks.
module tb_alu_decode_stage;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Valid;
    logic [31:0] i_Instr;
    logic [31:0] i_PC;
    logic [31:0] i_RsData0;
    logic [31:0] i_RsData1;
    logic        i_Stall;
    logic        i_Flush;
    logic        o_Ready;
    logic        o_Valid;
    logic [2:0]  o_Op;
    logic        o_fSub;
    logic        o_fSign;
    logic [31:0] o_Data0;
    logic [31:0] o_Data1;
    logic [31:0] o_Imm;
    logic [4:0]  o_Rd;
    logic        o_fWrite;
    logic        o_fLoad;
    logic        o_fStore;
    logic        o_fBranchOp;
    logic        o_fJump;
    logic        o_fIllegal;

    alu_decode_stage dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Valid     (i_Valid),
        .i_Instr     (i_Instr),
        .i_PC        (i_PC),
        .i_RsData0   (i_RsData0),
        .i_RsData1   (i_RsData1),
        .i_Stall     (i_Stall),
        .i_Flush     (i_Flush),
        .o_Ready     (o_Ready),
        .o_Valid     (o_Valid),
        .o_Op        (o_Op),
        .o_fSub      (o_fSub),
        .o_fSign     (o_fSign),
        .o_Data0     (o_Data0),
        .o_Data1     (o_Data1),
        .o_Imm       (o_Imm),
        .o_Rd        (o_Rd),
        .o_fWrite    (o_fWrite),
        .o_fLoad     (o_fLoad),
        .o_fStore    (o_fStore),
        .o_fBranchOp (o_fBranchOp),
        .o_fJump     (o_fJump),
        .o_fIllegal  (o_fIllegal)
    );

    always #5 i_Clk = ~i_Clk;

    // Full 7-bit RV32I major opcodes.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [2:0]  op;
        logic        f_sub;
        logic        f_sign;
        logic [31:0] data0;
        logic [31:0] data1;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        f_write;
        logic        f_load;
        logic        f_store;
        logic        f_branch;
        logic        f_jump;
        logic        f_illegal;
    } exp_t;

    int   n_total = 0;
    int   n_bad   = 0;
    logic cmp_en  = 1'b0;

    // Model state: what the stage output should hold after each edge.
    logic m_valid = 1'b0;
    logic m_known = 1'b0;
    exp_t m_f     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Immediates computed arithmetically from the instruction word.
    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return 32'($signed(ins) >>> 20);
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return (32'($signed(ins) >>> 20) & ~32'h1F) | 32'(ins[11:7]);
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return (32'($signed(ins) >>> 19) & 32'hFFFFF000) | (32'(ins[7]) << 11) |
               (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    endfunction
    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return ins & 32'hFFFFF000;
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return (32'($signed(ins) >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000) |
               (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    endfunction

    // What the stage should present for one instruction.
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        logic       ill;
        logic       writes;
        logic [2:0] f3;
        logic [6:0] f7;
        e      = '0;
        ill    = 1'b0;
        writes = 1'b0;
        f3     = ins[14:12];
        f7     = ins[31:25];
        case (ins[6:0])
            OPC_LOAD:   begin e.data0 = a; e.data1 = imm_i(ins); e.f_load = 1'b1; writes = 1'b1; end
            OPC_OPIMM: begin
                e.op = f3; e.data0 = a; e.data1 = imm_i(ins); writes = 1'b1;
                e.f_sub  = (f3 == 3'd2) || (f3 == 3'd3);
                e.f_sign = (f3 == 3'd5) ? ins[30] : 1'b0;
                ill = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                      ((f3 == 3'd5) && !((f7 == 7'h00) || (f7 == 7'h20)));
            end
            OPC_AUIPC:  begin e.data0 = pc; e.data1 = imm_u(ins); writes = 1'b1; end
            OPC_STORE: begin
                e.data0 = a; e.data1 = imm_s(ins); e.imm = imm_s(ins); e.f_store = 1'b1;
                ill = f3 > 3'd2;
            end
            OPC_OP: begin
                e.op = f3; e.data0 = a; e.data1 = b; writes = 1'b1;
                e.f_sub  = ((f3 == 3'd0) && ins[30]) || (f3 == 3'd2) || (f3 == 3'd3);
                e.f_sign = ins[30] && ((f3 == 3'd0) || (f3 == 3'd5));
                ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_LUI:    begin e.data1 = imm_u(ins); writes = 1'b1; end
            OPC_BRANCH: begin
                e.op = f3; e.f_sub = 1'b1; e.data0 = a; e.data1 = b; e.imm = imm_b(ins);
                e.f_branch = 1'b1;
                ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JALR: begin
                e.data0 = pc; e.data1 = 32'd4; e.imm = imm_i(ins); e.f_jump = 1'b1; writes = 1'b1;
                ill = f3 != 3'd0;
            end
            OPC_JAL:    begin e.data0 = pc; e.data1 = 32'd4; e.imm = imm_j(ins); e.f_jump = 1'b1; writes = 1'b1; end
            default:    ill = 1'b1;
        endcase
        if (writes) e.rd = ins[11:7];
        e.f_write = writes && (ins[11:7] != 5'd0) && !ill;
        if (ill) begin
            e.f_load = 1'b0; e.f_store = 1'b0; e.f_branch = 1'b0; e.f_jump = 1'b0;
        end
        e.f_illegal = ill;
        return e;
    endfunction

    // Load-use: a visible load whose rd is read by the presented instruction.
    function automatic logic model_hazard(input logic v_in, input logic [31:0] ins);
        logic uses1;
        logic uses2;
        uses1 = !((ins[6:0] == OPC_LUI) || (ins[6:0] == OPC_AUIPC) || (ins[6:0] == OPC_JAL));
        uses2 = (ins[6:0] == OPC_OP) || (ins[6:0] == OPC_STORE) || (ins[6:0] == OPC_BRANCH);
        return m_valid && m_f.f_load && (m_f.rd != 5'd0) && v_in &&
               ((uses1 && (ins[19:15] == m_f.rd)) || (uses2 && (ins[24:20] == m_f.rd)));
    endfunction

    // Advance the model at each rising edge using the inputs presented this cycle.
    always @(posedge i_Clk) begin
        logic haz;
        haz = model_hazard(i_Valid, i_Instr);
        if (i_Rst) begin
            m_valid = 1'b0; m_known = 1'b1; m_f = '0;
        end else if (i_Flush) begin
            m_valid = 1'b0; m_known = 1'b0;
        end else if (i_Stall) begin
            m_valid = m_valid;
        end else if (haz) begin
            m_valid = 1'b0; m_known = 1'b0;
        end else if (i_Valid) begin
            m_valid = 1'b1; m_known = 1'b1;
            m_f = model_decode(i_Instr, i_PC, i_RsData0, i_RsData1);
        end else begin
            m_valid = 1'b0; m_known = 1'b0;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge i_Clk) begin
        if (cmp_en) begin
            check("valid", 32'(o_Valid), 32'(m_valid));
            check("ready", 32'(o_Ready), 32'(!i_Stall && !model_hazard(i_Valid, i_Instr)));
            if (m_known) begin
                check("op",      32'(o_Op),        32'(m_f.op));
                check("f_sub",   32'(o_fSub),      32'(m_f.f_sub));
                check("f_sign",  32'(o_fSign),     32'(m_f.f_sign));
                check("data0",   o_Data0,          m_f.data0);
                check("data1",   o_Data1,          m_f.data1);
                check("imm",     o_Imm,            m_f.imm);
                check("rd",      32'(o_Rd),        32'(m_f.rd));
                check("f_write", 32'(o_fWrite),    32'(m_f.f_write));
                check("f_load",  32'(o_fLoad),     32'(m_f.f_load));
                check("f_store", 32'(o_fStore),    32'(m_f.f_store));
                check("f_br",    32'(o_fBranchOp), 32'(m_f.f_branch));
                check("f_jump",  32'(o_fJump),     32'(m_f.f_jump));
                check("f_ill",   32'(o_fIllegal),  32'(m_f.f_illegal));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        i_Valid = v; i_Instr = ins; i_PC = pc; i_RsData0 = a; i_RsData1 = b;
        #1;
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Present an instruction and keep re-presenting it until the stage takes it.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        int waits;
        waits = 0;
        drive(1'b1, ins, pc, a, b);
        while (!o_Ready && waits < 4) begin
            tick();
            waits++;
        end
        if (!o_Ready) check("issue_timeout", 32'(o_Ready), 32'd1);
        tick();
    endtask

    logic [31:0] misc_instr [10] = '{32'hABCDE3B7, 32'h004100E7, 32'h004110E7, 32'h402091B3,
                                     32'h40209193, 32'hFFF0B193, 32'h0020B623, 32'hFE20ACE3,
                                     32'h00000000, 32'h0020D2B3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Rst = 1'b1; i_Stall = 1'b0; i_Flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_data0", o_Data0, 32'd0);
        check("rst_rd",    32'(o_Rd), 32'd0);
        check("rst_ready", 32'(o_Ready), 32'd1);
        i_Rst = 1'b0;

        // ADD x3,x1,x2
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("add_valid", 32'(o_Valid), 32'd1);
        check("add_op",    32'(o_Op), 32'd0);
        check("add_sub",   32'(o_fSub), 32'd0);
        check("add_d0",    o_Data0, 32'd5);
        check("add_d1",    o_Data1, 32'd7);
        check("add_rd",    32'(o_Rd), 32'd3);
        check("add_wr",    32'(o_fWrite), 32'd1);

        // SUB x3,x1,x2
        issue(32'h402081B3, 32'h4, 32'd10, 32'd3);
        check("sub_sub",  32'(o_fSub), 32'd1);
        check("sub_sign", 32'(o_fSign), 32'd1);

        // SRAI x5,x6,4
        issue(32'h40435293, 32'h8, 32'h80000000, 32'h0);
        check("srai_op",   32'(o_Op), 32'd5);
        check("srai_sign", 32'(o_fSign), 32'd1);
        check("srai_sub",  32'(o_fSub), 32'd0);
        check("srai_d1",   o_Data1, 32'h404);

        // AUIPC x1,0x12345 at PC 0x100
        issue(32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF);
        check("auipc_d0", o_Data0, 32'h100);
        check("auipc_d1", o_Data1, 32'h12345000);
        check("auipc_rd", 32'(o_Rd), 32'd1);
        check("auipc_wr", 32'(o_fWrite), 32'd1);

        // LW x5 then ADD x6,x5,x5: one bubble
        issue(32'h0000A283, 32'h10, 32'h1000, 32'h0);
        check("lw_load", 32'(o_fLoad), 32'd1);
        check("lw_rd",   32'(o_Rd), 32'd5);
        drive(1'b1, 32'h00528333, 32'h14, 32'h55, 32'h55);
        check("lu_ready_low", 32'(o_Ready), 32'd0);
        tick();
        check("lu_bubble",    32'(o_Valid), 32'd0);
        check("lu_ready_up",  32'(o_Ready), 32'd1);
        tick();
        check("lu_add_valid", 32'(o_Valid), 32'd1);
        check("lu_add_rd",    32'(o_Rd), 32'd6);
        check("lu_add_d0",    o_Data0, 32'h55);

        // LW x0 then ADD x6,x0,x0: no bubble
        issue(32'h0000A003, 32'h18, 32'h2000, 32'h0);
        drive(1'b1, 32'h00000333, 32'h1C, 32'h0, 32'h0);
        check("x0_ready", 32'(o_Ready), 32'd1);
        tick();
        check("x0_valid", 32'(o_Valid), 32'd1);
        check("x0_rd",    32'(o_Rd), 32'd6);

        // Stall for three cycles, then flush while stalled
        issue(32'h002081B3, 32'h20, 32'd5, 32'd7);
        i_Stall = 1'b1;
        drive(1'b1, 32'h40435293, 32'h24, 32'd9, 32'd9);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(o_Ready), 32'd0);
            tick();
            check("stall_valid", 32'(o_Valid), 32'd1);
            check("stall_d0",    o_Data0, 32'd5);
            check("stall_d1",    o_Data1, 32'd7);
            check("stall_rd",    32'(o_Rd), 32'd3);
        end
        i_Flush = 1'b1;
        tick();
        check("flush_valid", 32'(o_Valid), 32'd0);
        i_Flush = 1'b0;
        i_Stall = 1'b0;

        // Undecodable word
        issue(32'hFFFFFFFF, 32'h28, 32'h1, 32'h2);
        check("ill_valid", 32'(o_Valid), 32'd1);
        check("ill_flag",  32'(o_fIllegal), 32'd1);
        check("ill_wr",    32'(o_fWrite), 32'd0);

        // BEQ x1,x2,-8
        issue(32'hFE208CE3, 32'h40, 32'd1, 32'd1);
        check("beq_imm", o_Imm, 32'hFFFFFFF8);
        check("beq_br",  32'(o_fBranchOp), 32'd1);
        check("beq_sub", 32'(o_fSub), 32'd1);

        // SW x2,12(x1)
        issue(32'h0020A623, 32'h44, 32'h300, 32'h77);
        check("sw_imm", o_Imm, 32'd12);
        check("sw_st",  32'(o_fStore), 32'd1);

        // JAL x1,+16 at PC 0x200
        issue(32'h010000EF, 32'h200, 32'h0, 32'h0);
        check("jal_imm", o_Imm, 32'd16);
        check("jal_d0",  o_Data0, 32'h200);
        check("jal_d1",  o_Data1, 32'd4);
        check("jal_j",   32'(o_fJump), 32'd1);

        // Remaining classes and illegal encodings, checked by the model
        foreach (misc_instr[k]) begin
            issue(misc_instr[k], 32'h300 + 32'(k) * 4, 32'h1111 * 32'(k + 1), 32'hF0F0_0000 + 32'(k));
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        // LW x5 then SW x5,0(x1): hazard through rs2 only
        issue(32'h0000A283, 32'h400, 32'h10, 32'h0);
        issue(32'h0050A023, 32'h404, 32'h20, 32'h30);
        // LW x5 then LUI whose rs1 field is x5: no hazard
        issue(32'h0000A283, 32'h408, 32'h10, 32'h0);
        drive(1'b1, 32'h000282B7, 32'h40C, 32'h0, 32'h0);
        check("lui_ready", 32'(o_Ready), 32'd1);
        tick();

        // Reset in the middle of a load-use hazard
        issue(32'h0000A283, 32'h500, 32'h10, 32'h0);
        drive(1'b1, 32'h00528333, 32'h504, 32'h1, 32'h1);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        check("mid_rst_valid", 32'(o_Valid), 32'd0);
        check("mid_rst_d0",    o_Data0, 32'd0);
        check("mid_rst_rd",    32'(o_Rd), 32'd0);
        check("mid_rst_load",  32'(o_fLoad), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("mid_rst_ready", 32'(o_Ready), 32'd1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered instruction-decode stage that produces the ALU's control and operand inputs (op, sub flag, sign flag, two 32-bit operands) from a fetched RV32I instruction. It also produces the immediate, destination and write-enable fields for later stages. It sits between fetch/register-file read and the ALU, adds one pipeline register, and inserts a one-cycle bubble on load-use hazards. The ALU consumes its outputs directly.

## Interface
- No parameters. Widths are fixed to RV32I.
- i_Clk in 1: clock, rising edge.
- i_Rst in 1: reset, synchronous, active-high.
- i_Valid in 1: i_Instr/i_PC/i_RsData* are valid this cycle.
- i_Instr in 32: instruction.
- i_PC in 32: instruction address.
- i_RsData0 in 32: register-file read of rs1 (instr[19:15]), same cycle.
- i_RsData1 in 32: register-file read of rs2 (instr[24:20]), same cycle.
- i_Stall in 1: downstream stall; hold all outputs.
- i_Flush in 1: kill instruction being accepted and the one held.
- o_Ready out 1: combinational; `!i_Stall && !Hazard`.
- o_Valid out 1: output fields are valid.
- o_Op out 3: ALU op or branch code (funct3 semantics).
- o_fSub out 1: ALU subtracts.
- o_fSign out 1: arithmetic shift / signed subtract.
- o_Data0 out 32: ALU operand 0.
- o_Data1 out 32: ALU operand 1.
- o_Imm out 32: sign-extended immediate (branch/jump/store offset).
- o_Rd out 5: destination register.
- o_fWrite out 1: writes rd.
- o_fLoad out 1: load instruction.
- o_fStore out 1: store instruction.
- o_fBranchOp out 1: conditional branch.
- o_fJump out 1: JAL or JALR.
- o_fIllegal out 1: undecodable instruction.

## Operation
- Opcode class = instr[6:2], valid only if instr[1:0]=2'b11.
- Class LOAD=0:
  - Op=0, Data0=rs1, Data1=I-imm, fLoad=1.
- Class OPIMM=4:
  - Op=funct3, Data0=rs1, Data1=I-imm.
  - fSub=1 for funct3 2/3 (SLTI/SLTIU).
  - fSign=instr[30] only for funct3 5.
  - Illegal if funct3=1 and instr[31:25]≠0.
  - Illegal if funct3=5 and instr[31:25]∉{0x00,0x20}.
- Class AUIPC=5:
  - Op=0, Data0=PC, Data1=U-imm.
- Class STORE=8:
  - Op=0, Data0=rs1, Data1=S-imm, Imm=S-imm, fStore=1.
  - funct3>2 illegal.
- Class R_TYPE=12:
  - Op=funct3, Data0=rs1, Data1=rs2.
  - fSub=1 for SUB, SLT, SLTU.
  - fSign=1 for SUB, SRA.
  - instr[31:25] must be 0x00, or 0x20 with funct3∈{0,5}; otherwise illegal.
- Class LUI=13:
  - Op=0, Data0=0, Data1=U-imm.
- Class BRANCH=24:
  - Op=funct3, fSub=1, Data0=rs1, Data1=rs2, Imm=B-imm, fBranchOp=1.
  - funct3 2/3 illegal.
- Class JALR=25:
  - Op=0, Data0=PC, Data1=4, Imm=I-imm, fJump=1.
  - funct3≠0 illegal.
- Class JAL=27:
  - Op=0, Data0=PC, Data1=4, Imm=J-imm, fJump=1.
- Any other class is illegal.
- An illegal instruction forces fWrite, fLoad, fStore, fBranchOp and fJump to 0. It still sets o_Valid=1 with o_fIllegal=1.
- o_fWrite=1 only when rd≠0, the instruction is legal, and class∈{LOAD, OPIMM, AUIPC, R_TYPE, LUI, JALR, JAL}.
- Fields not listed for a class are 0.
- rs1 is used by all classes except LUI, AUIPC and JAL.
- rs2 is used only by R_TYPE, STORE and BRANCH.
- Hazard = `o_Valid && o_fLoad && o_Rd≠0 && i_Valid && ((rs1 used && rs1==o_Rd) || (rs2 used && rs2==o_Rd))`.

## Timing
- Latency: 1 cycle from accept to o_Valid.
- Accept = i_Valid && o_Ready && !i_Flush at a rising edge. On accept, all outputs load and o_Valid←1.
- Edge priority, highest first:
  1. i_Rst.
  2. i_Flush: o_Valid←0; other fields don't-care.
  3. i_Stall: every output register holds.
  4. Hazard: o_Valid←0 (bubble); the upstream instruction is not accepted and is re-presented next cycle.
  5. Accept.
  6. Otherwise o_Valid←0.
- During a hazard the load is already visible on the outputs. The bubble clears o_Valid, so Hazard is 0 the next cycle and that instruction is then accepted.
- Reset: all output registers 0, o_Valid=0. Consequently o_Ready=!i_Stall.
- Reset asserted mid-stall or mid-hazard clears everything in the same cycle; no bubble carries over.
- Flush together with stall: o_Valid←0 (flush wins).

## Structure
- Package alu_decode_pkg holds:
  - opcode class constants (LOAD=0, OPIMM=4, AUIPC=5, STORE=8, R_TYPE=12, LUI=13, BRANCH=24, JALR=25, JAL=27);
  - funct3 constants (ADD..AND, BEQ..BGEU) shared with the ALU.
- Sub-module imm_gen: combinational I/S/B/U/J immediate extraction selected by class.
- Hazard logic and the output register live in the top module.

## Test plan
- 0x002081B3 (ADD x3,x1,x2), RsData0=5, RsData1=7 → next cycle: Valid=1, Op=0, fSub=0, Data0=5, Data1=7, Rd=3, fWrite=1.
- 0x402081B3 (SUB) → fSub=1, fSign=1.
- 0x40435293 (SRAI x5,x6,4) → Op=5, fSign=1, fSub=0, Data1=0x404.
- 0x12345097 (AUIPC x1) at PC=0x100 → Data0=0x100, Data1=0x12345000, Rd=1, fWrite=1.
- 0x0000A283 (LW x5) accepted, then 0x00528333 (ADD x6,x5,x5) presented:
  - o_Ready=0 for 1 cycle, then o_Valid=0 for 1 cycle;
  - ADD accepted on the following edge.
  - Same sequence with rd=x0 → no bubble.
- Stall held 3 cycles → outputs unchanged.
- Flush during the stall → o_Valid=0.
- 0xFFFFFFFF → fIllegal=1, fWrite=0.
- Reset asserted mid-stream → all outputs 0 next cycle.
